// File: rtl/microwave_cook_sequencer.sv
// Microwave cook sequencer: keypad MM:SS entry, per-second BCD countdown, magnetron and door interlock.
// Optional done beep is compiled in with `define DONE_BEEP_EN.
module microwave_cook_sequencer #(
    parameter int unsigned TICK_CYCLES = 50000000,
    parameter int unsigned TICK_W      = 26,
    parameter int unsigned BEEP_SECS   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        closed_door,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    output logic        magnetron,
    output logic        finished_time,
    output logic [15:0] time_bcd,
    output logic [2:0]  state,
    output logic        beep
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    state_t              state_q, state_d;
    logic [15:0]         time_q, time_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                start_q, stop_q, clear_q;

    logic                start_rise, stop_rise, clear_rise;
    logic                key_ok, start_ok, tick_wrap;
    logic [15:0]         time_dec;

`ifdef DONE_BEEP_EN
    localparam int unsigned BEEP_W = $clog2(BEEP_SECS + 1);
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
`endif

    // Borrowing BCD decrement; seconds tens wrap to 5, all ones digits wrap to 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign start_rise = start & ~start_q;
    assign stop_rise  = stop  & ~stop_q;
    assign clear_rise = clear & ~clear_q;

    assign key_ok    = key_valid && (key_digit <= 4'd9);
    assign start_ok  = start_rise && closed_door && (time_q != 16'h0000) && (time_q[7:4] <= 4'd5);
    assign tick_wrap = (tick_q == TICK_LAST);
    assign time_dec  = bcd_dec(time_q);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        time_d  = time_q;
        tick_d  = tick_q;
`ifdef DONE_BEEP_EN
        beep_cnt_d = beep_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_SET: begin
                if (clear_rise || stop_rise) begin
                    state_d = ST_IDLE;
                    time_d  = '0;
                end else if (start_ok) begin
                    state_d = ST_COOK;
                    tick_d  = '0;
                end else if (key_ok) begin
                    state_d = ST_SET;
                    time_d  = {time_q[11:0], key_digit};
                end
            end
            ST_COOK: begin
                if (clear_rise) begin
                    state_d = ST_IDLE;
                    time_d  = '0;
                    tick_d  = '0;
                end else if (stop_rise || !closed_door) begin
                    state_d = ST_PAUSE;
                end else if (tick_wrap) begin
                    tick_d = '0;
                    time_d = time_dec;
                    if (time_q == 16'h0001) begin
                        state_d = ST_DONE;
`ifdef DONE_BEEP_EN
                        beep_cnt_d = BEEP_W'(BEEP_SECS);
`endif
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_PAUSE: begin
                // Tick count is held so a resume finishes the partial second.
                if (clear_rise || stop_rise) begin
                    state_d = ST_IDLE;
                    time_d  = '0;
                    tick_d  = '0;
                end else if (start_ok) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (clear_rise || stop_rise || !closed_door) begin
                    state_d = ST_IDLE;
                    time_d  = '0;
                    tick_d  = '0;
                end
`ifdef DONE_BEEP_EN
                else begin
                    tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
                    if (tick_wrap && (beep_cnt_q != '0)) begin
                        beep_cnt_d = beep_cnt_q - BEEP_W'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                time_d  = '0;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            tick_q  <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
            start_q <= start;
            stop_q  <= stop;
            clear_q <= clear;
        end
    end

`ifdef DONE_BEEP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt_q <= '0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign beep = (state_q == ST_DONE) && (beep_cnt_q != '0);
`else
    assign beep = 1'b0;
`endif

    // Door interlock and reset act combinationally, ahead of the PAUSE transition.
    assign magnetron     = (state_q == ST_COOK) && closed_door && rst_n;
    assign finished_time = (state_q == ST_DONE);
    assign time_bcd      = time_q;
    assign state         = state_q;

endmodule

// File: tb/tb_microwave_cook_sequencer.sv
// Self-checking bench for microwave_cook_sequencer: directed scenarios plus randomized buttons/keys
// compared each cycle against a seconds-based reference model.
module tb_microwave_cook_sequencer;

    localparam int TICK = 10;
    localparam int BEEP = 3;

    logic        clk;
    logic        rst_n;
    logic        start, stop, clear, closed_door, key_valid;
    logic [3:0]  key_digit;
    logic        magnetron, finished_time, beep;
    logic [15:0] time_bcd;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: state number, entered digits, remaining seconds, cycles into current second.
    int m_state;
    int m_dig[4];
    int m_secs;
    int m_ticks;
    int m_done_cyc;
    bit p_start, p_stop, p_clear;

    microwave_cook_sequencer #(
        .TICK_CYCLES(TICK),
        .TICK_W     (4),
        .BEEP_SECS  (BEEP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .closed_door  (closed_door),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .magnetron    (magnetron),
        .finished_time(finished_time),
        .time_bcd     (time_bcd),
        .state        (state),
        .beep         (beep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_time();
        int mm, ss;
        if (m_state <= 1)
            return {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])};
        mm = m_secs / 60;
        ss = m_secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit m_beep();
`ifdef DONE_BEEP_EN
        return (m_state == 4) && (m_done_cyc < BEEP * TICK);
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_zero();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
    endtask

    task automatic m_reset();
        m_state = 0;
        m_zero();
        m_secs = 0;
        m_ticks = 0;
        m_done_cyc = 0;
        p_start = 0;
        p_stop = 0;
        p_clear = 0;
    endtask

    task automatic model_step();
        bit rs, ss, cs, t_ok;
        int nst;
        rs = start && !p_start;
        ss = stop && !p_stop;
        cs = clear && !p_clear;
        t_ok = closed_door && (m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3] != 0) && (m_dig[2] <= 5);
        nst = m_state;
        case (m_state)
            0, 1: begin
                if (cs || ss) begin
                    nst = 0;
                    m_zero();
                end else if (rs && t_ok) begin
                    nst = 2;
                    m_secs = (m_dig[0] * 10 + m_dig[1]) * 60 + m_dig[2] * 10 + m_dig[3];
                    m_ticks = 0;
                end else if (key_valid && key_digit < 10) begin
                    m_dig[0] = m_dig[1];
                    m_dig[1] = m_dig[2];
                    m_dig[2] = m_dig[3];
                    m_dig[3] = int'(key_digit);
                    nst = 1;
                end
            end
            2: begin
                if (cs) begin
                    nst = 0;
                    m_zero();
                end else if (ss || !closed_door) begin
                    nst = 3;
                end else begin
                    m_ticks++;
                    if (m_ticks == TICK) begin
                        m_ticks = 0;
                        m_secs--;
                        if (m_secs == 0) begin
                            nst = 4;
                            m_done_cyc = 0;
                        end
                    end
                end
            end
            3: begin
                if (cs || ss) begin
                    nst = 0;
                    m_zero();
                end else if (rs && closed_door) begin
                    nst = 2;
                end
            end
            default: begin
                if (cs || ss || !closed_door) begin
                    nst = 0;
                    m_zero();
                end else begin
                    m_done_cyc++;
                end
            end
        endcase
        m_state = nst;
        p_start = start;
        p_stop = stop;
        p_clear = clear;
    endtask

    // One clock cycle with the inputs already applied; compares every output to the model.
    task automatic cycle();
        @(negedge clk);
        check("magnetron_comb", 16'(magnetron), 16'((m_state == 2) && closed_door));
        @(posedge clk);
        model_step();
        #1;
        check("state", 16'(state), 16'(m_state));
        check("time_bcd", time_bcd, m_time());
        check("finished_time", 16'(finished_time), 16'(m_state == 4));
        check("magnetron", 16'(magnetron), 16'((m_state == 2) && closed_door));
        check("beep", 16'(beep), 16'(m_beep()));
    endtask

    task automatic drive(input logic st, input logic sp, input logic cl, input logic dr,
                         input logic kv, input logic [3:0] kd);
        start = st;
        stop = sp;
        clear = cl;
        closed_door = dr;
        key_valid = kv;
        key_digit = kd;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1, 0, 4'd0);
    endtask

    task automatic key(input logic [3:0] d);
        drive(0, 0, 0, 1, 1, d);
    endtask

    task automatic clear_pulse();
        drive(0, 0, 1, 1, 0, 4'd0);
        drive(0, 0, 0, 1, 0, 4'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_magnetron_now", 16'(magnetron), 16'h0);
        start = 0;
        stop = 0;
        clear = 0;
        key_valid = 0;
        key_digit = 0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_state", 16'(state), 16'h0);
        check("rst_time", time_bcd, 16'h0000);
        check("rst_finished", 16'(finished_time), 16'h0);
        check("rst_beep", 16'(beep), 16'h0);
        check("rst_magnetron", 16'(magnetron), 16'h0);
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        start = 0; stop = 0; clear = 0; closed_door = 1; key_valid = 0; key_digit = 0;
        m_reset();
        #3;
        do_reset();

        // 00:15 cook to completion.
        key(4'd1);
        key(4'd5);
        drive(1, 0, 0, 1, 0, 4'd0);
        check("s1_time_start", time_bcd, 16'h0015);
        check("s1_mag_start", 16'(magnetron), 16'h1);
        idle(150);
        check("s1_time_done", time_bcd, 16'h0000);
        check("s1_state_done", 16'(state), 16'h4);
        check("s1_finished", 16'(finished_time), 16'h1);
        check("s1_mag_done", 16'(magnetron), 16'h0);
        idle(5);
        clear_pulse();

        // 01:00 borrow across minutes, then stop twice.
        key(4'd1); key(4'd0); key(4'd0);
        check("s2_entry", time_bcd, 16'h0100);
        drive(1, 0, 0, 1, 0, 4'd0);
        idle(10);
        check("s2_first_tick", time_bcd, 16'h0059);
        idle(10);
        check("s2_second_tick", time_bcd, 16'h0058);
        drive(0, 1, 0, 1, 0, 4'd0);
        check("s2_pause", 16'(state), 16'h3);
        drive(0, 0, 0, 1, 0, 4'd0);
        drive(0, 1, 0, 1, 0, 4'd0);
        check("s2_cancel_state", 16'(state), 16'h0);
        check("s2_cancel_time", time_bcd, 16'h0000);
        drive(0, 0, 0, 1, 0, 4'd0);

        // Door opened mid-cook, closed, then resumed.
        key(4'd7);
        drive(1, 0, 0, 1, 0, 4'd0);
        idle(4);
        drive(0, 0, 0, 0, 0, 4'd0);
        check("s3_paused", 16'(state), 16'h3);
        check("s3_frozen", time_bcd, 16'h0007);
        drive(0, 0, 0, 1, 0, 4'd0);
        idle(3);
        check("s3_door_closed_only", 16'(state), 16'h3);
        drive(1, 0, 0, 1, 0, 4'd0);
        n = 0;
        while (n < 200 && state != 3'd4) begin
            drive(0, 0, 0, 1, 0, 4'd0);
            n++;
        end
        check("s3_resume_cycles", 16'(n), 16'(7 * TICK - 4));
        idle(35);
        clear_pulse();

        // Rejected starts.
        key(4'd1); key(4'd0);
        drive(1, 0, 0, 0, 0, 4'd0);
        check("s4_door_open_state", 16'(state), 16'h1);
        check("s4_door_open_mag", 16'(magnetron), 16'h0);
        drive(0, 0, 0, 1, 0, 4'd0);
        clear_pulse();
        key(4'd0);
        drive(1, 0, 0, 1, 0, 4'd0);
        check("s4_zero_state", 16'(state), 16'h1);
        drive(0, 0, 0, 1, 0, 4'd0);
        clear_pulse();
        key(4'd7); key(4'd5);
        drive(1, 0, 0, 1, 0, 4'd0);
        check("s4_bad_secs_state", 16'(state), 16'h1);
        check("s4_bad_secs_mag", 16'(magnetron), 16'h0);
        drive(0, 0, 0, 1, 0, 4'd0);
        clear_pulse();

        // Clear beats start in the same cycle.
        key(4'd1); key(4'd5);
        drive(1, 0, 1, 1, 0, 4'd0);
        check("s5_state", 16'(state), 16'h0);
        check("s5_time", time_bcd, 16'h0000);
        drive(0, 0, 0, 1, 0, 4'd0);

        // Reset while cooking.
        key(4'd3);
        drive(1, 0, 0, 1, 0, 4'd0);
        idle(5);
        do_reset();

        // Randomized buttons, door and keys.
        for (int i = 0; i < 4000; i++) begin
            logic st, sp, cl, dr, kv;
            logic [3:0] kd;
            st = ($urandom_range(0, 9) == 0) ? ~start : start;
            sp = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 79) == 0);
            dr = ($urandom_range(0, 49) == 0) ? ~closed_door : closed_door;
            kv = ($urandom_range(0, 4) == 0);
            kd = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 999) == 0) do_reset();
            drive(st, sp, cl, dr, kv, kd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
